seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
- Run-time controller for the overlapping sequence detector.
- Holds a programmable pattern and length, selects Moore/Mealy output mode (M), and sequences the history/state register through IDLE and RUN phases.
- Qualifies serial input with a valid strobe and reports detections plus a saturating hit count to the surrounding datapath.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- LEN_W, 4: width of cfg_len; must hold MAX_LEN.
- CNT_W, 8: width of the hit counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- cfg_mode  in  1  M: 0 = Moore, 1 = Mealy.
- start  in  1  IDLE->RUN request.
- stop  in  1  RUN->IDLE request.
- din  in  1  serial data bit.
- din_valid  in  1  din qualifier; bit accepted only in RUN with din_valid=1.
- det  out  1  detection strobe.
- busy  out  1  1 while in RUN.
- cfg_err  out  1  one-cycle pulse on rejected config write.
- hit_cnt  out  CNT_W  saturating detection count since last start.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; pattern=0; len=1; mode=0; history=0; fill=0; hit_cnt=0.
  - busy=0, cfg_err=0, registered det=0.
  - Reset overrides all other inputs, including mid-RUN.
- FSM IDLE:
  - cfg_we with 1<=cfg_len<=MAX_LEN: latch pattern/len/mode next edge.
  - cfg_we with cfg_len=0 or >MAX_LEN: config unchanged, cfg_err=1 next cycle for one cycle.
  - start=1: go to RUN; clear history, fill, hit_cnt that edge.
  - start and cfg_we in the same cycle: config is latched AND RUN entered; the new config applies to the first accepted bit.
  - din ignored in IDLE.
- FSM RUN:
  - Accepted bit (din_valid=1): history <= {history[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
  - cfg_we in RUN: ignored, cfg_err pulse.
  - stop=1: go to IDLE next edge. A bit accepted in the same cycle is still processed (det and hit_cnt update).
  - start in RUN: ignored. start and stop together in IDLE: start wins.
- Match (evaluated on an accepted bit):
  - next = {history, din}.
  - match = (fill+1 >= len) AND next[len-1:0] == pattern[len-1:0].
  - Overlap is inherent: history is never cleared on a match.
- Mealy (mode=1):
  - det = combinational match, high in the same cycle din is presented.
  - No det when din_valid=0 or not in RUN.
- Moore (mode=0):
  - det registered: high exactly one cycle after the accepting cycle, for one cycle.
  - Two back-to-back matches give det high on two consecutive cycles.
- Mode is latched only in IDLE; no mid-run mode switch.
- hit_cnt increments on each match edge and saturates at 2^CNT_W-1. hit_cnt is held in IDLE.
- busy mirrors state==RUN (registered).
- len=1: every accepted bit equal to pattern[0] is a match.

Test Plan:
1. Config pattern=4'b1011, len=4, mode=1; start; din 1,0,1,1,0,1,1 all valid -> det high in the same cycle as bits 4 and 7; hit_cnt=2.
2. Same stream, mode=0 -> det high the cycle after bits 4 and 7; no det on other cycles; hit_cnt=2.
3. Same as 1 with din_valid=0 gaps of 1-3 cycles between bits -> identical detections; no det during gaps; history unchanged across gaps.
4. In RUN, cfg_we with len=3 -> cfg_err one-cycle pulse; detection of 1011 continues. In IDLE, cfg_len=0 -> cfg_err; len remains 4.
5. In RUN after bits 1,0,1: stop; then start; then bits 1,0,1,1 -> single det only after the 4th post-start bit (history cleared); hit_cnt restarts at 0 then reaches 1.
6. CNT_W=2, pattern=1, len=1, six valid 1s -> hit_cnt 1,2,3,3,3,3. Then reset=0 mid-RUN -> next cycle busy=0, hit_cnt=0, det=0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time controller for an overlapping serial sequence
// detector with a programmable pattern/length, Moore or Mealy detection
// output and a saturating hit counter.
module seq_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_mode,
   input  logic               start,
   input  logic               stop,
   input  logic               din,
   input  logic               din_valid,
   output logic               det,
   output logic               busy,
   output logic               cfg_err,
   output logic [CNT_W-1:0]   hit_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_LEN_L = LEN_W'(1);
   localparam logic [MAX_LEN:0] ONE_WIDE  = {{MAX_LEN{1'b0}}, 1'b1};

   state_t               state_r;
   state_t               state_s;
   logic [MAX_LEN-1:0]   pattern_r;
   logic [LEN_W-1:0]     len_r;
   logic                 mode_r;
   logic [MAX_LEN-1:0]   history_r;
   logic [LEN_W-1:0]     fill_r;
   logic [CNT_W-1:0]     hit_cnt_r;
   logic                 busy_r;
   logic                 cfg_err_r;
   logic                 det_r;

   logic                 cfg_ok_s;
   logic                 accept_s;
   logic                 match_s;
   logic [MAX_LEN:0]     next_bits_s;
   logic [MAX_LEN:0]     mask_s;
   logic [LEN_W:0]       fill_inc_s;

   // Qualify the incoming bit and evaluate the pattern match against the
   // shifted-in window {history, din}; only the low len bits are compared.
   always_comb begin
      cfg_ok_s    = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_LEN_L);
      accept_s    = (state_r == ST_RUN) && din_valid;
      next_bits_s = {history_r, din};
      mask_s      = (ONE_WIDE << len_r) - ONE_WIDE;
      fill_inc_s  = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
      if (accept_s) begin
         match_s = (fill_inc_s >= {1'b0, len_r}) &&
                   ((next_bits_s & mask_s) == ({1'b0, pattern_r} & mask_s));
      end else begin
         match_s = 1'b0;
      end
   end

   // Next-state logic: start wins in IDLE, stop ends RUN.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_RUN);
      end
   end

   // Configuration, history window, fill level, Moore detect and hit counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pattern_r <= {MAX_LEN{1'b0}};
         len_r     <= ONE_LEN_L;
         mode_r    <= 1'b0;
         history_r <= {MAX_LEN{1'b0}};
         fill_r    <= {LEN_W{1'b0}};
         hit_cnt_r <= {CNT_W{1'b0}};
         cfg_err_r <= 1'b0;
         det_r     <= 1'b0;
      end else begin
         // Writes are rejected while running or when the length is illegal.
         cfg_err_r <= cfg_we && ((state_r == ST_RUN) || !cfg_ok_s);
         det_r     <= match_s;
         if (cfg_we && (state_r == ST_IDLE) && cfg_ok_s) begin
            pattern_r <= cfg_pattern;
            len_r     <= cfg_len;
            mode_r    <= cfg_mode;
         end
         if ((state_r == ST_IDLE) && start) begin
            history_r <= {MAX_LEN{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            hit_cnt_r <= {CNT_W{1'b0}};
         end else if (accept_s) begin
            // History is never cleared on a match, so overlaps are found.
            history_r <= next_bits_s[MAX_LEN-1:0];
            if (fill_r != MAX_LEN_L) begin
               fill_r <= fill_inc_s[LEN_W-1:0];
            end
            if (match_s && (hit_cnt_r != {CNT_W{1'b1}})) begin
               hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Mealy mode exposes the same-cycle match; Moore mode the registered one.
   always_comb begin
      if (mode_r) begin
         det = match_s;
      end else begin
         det = det_r;
      end
   end

   assign busy    = busy_r;
   assign cfg_err = cfg_err_r;
   assign hit_cnt = hit_cnt_r;

endmodule
